// File: rtl/vending_machine.sv
// Purpose : 20-cent soda vending controller; accumulates nickel/dime/quarter credit and dispenses with change in nickels.
// Latency : a coin sampled at rising edge k drives o_soda/o_change from edge k until edge k+1 (registered outputs).
// Backpressure: none; one coin is accepted every cycle, and a sale cycle may also accept the first coin of the next sale.
//
// Ports:
//   i_clk      rising-edge system clock
//   i_rst_n    asynchronous active-low reset (credit and outputs cleared immediately)
//   i_nickle   5-cent coin level, one coin counted per edge while high
//   i_dime     10-cent coin level, one coin counted per edge while high
//   i_quarter  25-cent coin level, one coin counted per edge while high
//   o_soda     one-cycle dispense pulse per sale
//   o_change   change owed in nickels (0..4), zero whenever o_soda is low
module vending_machine (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_nickle,
    input  logic       i_dime,
    input  logic       i_quarter,
    output logic       o_soda,
    output logic [2:0] o_change
);

    typedef enum logic [1:0] {
        S0  = 2'd0,
        S5  = 2'd1,
        S10 = 2'd2,
        S15 = 2'd3
    } state_t;

    localparam logic [5:0] PRICE = 6'd20;

    state_t     state_q, state_d;
    logic       soda_q, soda_d;
    logic [2:0] change_q, change_d;

    logic [5:0] credit;
    logic [5:0] coin_val;
    logic       coin_vld;
    logic [5:0] sum;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S0;
            soda_q   <= 1'b0;
            change_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            soda_q   <= soda_d;
            change_q <= change_d;
        end
    end

    always_comb begin
        credit   = 6'd0;
        coin_val = 6'd0;
        coin_vld = 1'b0;
        sum      = 6'd0;
        state_d  = state_q;
        soda_d   = 1'b0;
        change_d = 3'd0;

        case (state_q)
            S0:      credit = 6'd0;
            S5:      credit = 6'd5;
            S10:     credit = 6'd10;
            S15:     credit = 6'd15;
            default: credit = 6'd0;
        endcase

        // Only the most valuable coin counts in a cycle; the others are dropped.
        if (i_quarter) begin
            coin_val = 6'd25;
            coin_vld = 1'b1;
        end else if (i_dime) begin
            coin_val = 6'd10;
            coin_vld = 1'b1;
        end else if (i_nickle) begin
            coin_val = 6'd5;
            coin_vld = 1'b1;
        end

        sum = credit + coin_val;

        if (coin_vld) begin
            if (sum >= PRICE) begin
                // Sale: credit always restarts from zero, surplus returned as nickels.
                state_d = S0;
                soda_d  = 1'b1;
                case (sum)
                    6'd25:   change_d = 3'd1;
                    6'd30:   change_d = 3'd2;
                    6'd35:   change_d = 3'd3;
                    6'd40:   change_d = 3'd4;
                    default: change_d = 3'd0;
                endcase
            end else begin
                case (sum)
                    6'd5:    state_d = S5;
                    6'd10:   state_d = S10;
                    6'd15:   state_d = S15;
                    default: state_d = S0;
                endcase
            end
        end
    end

    assign o_soda   = soda_q;
    assign o_change = change_q;

endmodule

// File: tb/tb_vending_machine.sv
module tb_vending_machine;

    logic       clk;
    logic       rst_n;
    logic       nickle;
    logic       dime;
    logic       quarter;
    logic       soda;
    logic [2:0] change;

    typedef struct packed {
        logic       soda;
        logic [2:0] chg;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    vending_machine dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_nickle  (nickle),
        .i_dime    (dime),
        .i_quarter (quarter),
        .o_soda    (soda),
        .o_change  (change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: the outputs registered at each edge are compared against the
    // oldest expectation issued by the driver.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (soda !== e.soda || change !== e.chg) begin
                failures++;
                $display("FAIL sale_output: got soda=%b change=%0d, expected soda=%b change=%0d at t=%0t",
                         soda, change, e.soda, e.chg, $time);
            end
        end
    end

    // One cycle of stimulus with the hand-computed output it must produce.
    task automatic coin(input logic n, input logic d, input logic q,
                        input logic exp_soda, input logic [2:0] exp_chg);
        exp_t e;
        @(negedge clk);
        nickle  = n;
        dime    = d;
        quarter = q;
        e.soda  = exp_soda;
        e.chg   = exp_chg;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (soda !== 1'b0 || change !== 3'd0) begin
            failures++;
            $display("FAIL %s: got soda=%b change=%0d, expected soda=0 change=0", name, soda, change);
        end
    endtask

    task automatic drain();
        int budget;
        budget = 5;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            #2;
            budget--;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        nickle  = 1'b0;
        dime    = 1'b0;
        quarter = 1'b0;
        #1;
        check_reset_outputs("power_on_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset: no sale.
        coin(0, 0, 0, 0, 3'd0);
        coin(0, 0, 0, 0, 3'd0);

        // Nickel + dime = 15, then reset discards the credit.
        coin(1, 0, 0, 0, 3'd0);
        coin(0, 1, 0, 0, 3'd0);
        drain();
        @(negedge clk);
        nickle = 1'b0;
        dime   = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_reset_outputs("reset_mid_credit");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        coin(0, 1, 0, 0, 3'd0);   // 10: would have been a sale had 15 survived
        coin(0, 1, 0, 1, 3'd0);   // 20 exact
        coin(0, 0, 0, 0, 3'd0);

        // Dime, idle, quarter = 35 -> change 3.
        coin(0, 1, 0, 0, 3'd0);
        coin(0, 0, 0, 0, 3'd0);
        coin(0, 0, 1, 1, 3'd3);
        coin(0, 0, 0, 0, 3'd0);

        // Nickel, dime, quarter = 40 -> change 4.
        coin(1, 0, 0, 0, 3'd0);
        coin(0, 1, 0, 0, 3'd0);
        coin(0, 0, 1, 1, 3'd4);
        coin(0, 0, 0, 0, 3'd0);

        // Nickel, idle, quarter = 30 -> change 2.
        coin(1, 0, 0, 0, 3'd0);
        coin(0, 0, 0, 0, 3'd0);
        coin(0, 0, 1, 1, 3'd2);
        coin(0, 0, 0, 0, 3'd0);

        // Nickel, dime, nickel with idles = 20 exact; then credit 5 carries.
        coin(1, 0, 0, 0, 3'd0);
        coin(0, 0, 0, 0, 3'd0);
        coin(0, 1, 0, 0, 3'd0);
        coin(0, 0, 0, 0, 3'd0);
        coin(1, 0, 0, 1, 3'd0);
        coin(1, 0, 0, 0, 3'd0);   // credit 5
        coin(0, 1, 0, 0, 3'd0);   // credit 15
        coin(1, 0, 0, 1, 3'd0);   // 20 exact
        coin(0, 0, 0, 0, 3'd0);

        // All three high counts as a quarter; held quarter sells every cycle.
        coin(1, 1, 1, 1, 3'd1);
        coin(0, 0, 1, 1, 3'd1);
        coin(0, 0, 1, 1, 3'd1);
        coin(0, 0, 0, 0, 3'd0);

        // Dime beats nickel; 15 + quarter = 40.
        coin(1, 1, 0, 0, 3'd0);   // 10, nickel dropped
        coin(1, 0, 0, 0, 3'd0);   // 15
        coin(0, 0, 1, 1, 3'd4);   // 40
        coin(0, 0, 0, 0, 3'd0);

        // Asynchronous reset while dispensing clears the pulse immediately.
        coin(0, 0, 1, 1, 3'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_during_soda");
        @(negedge clk);
        quarter = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        coin(0, 1, 0, 0, 3'd0);
        coin(0, 1, 0, 1, 3'd0);
        coin(0, 0, 0, 0, 3'd0);

        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
